// File: rtl/i2c_mem_slave.sv
// I2C target with a byte-addressed register file. scl/sda are oversampled on clk;
// START/STOP/bit edges come from the synchronised copies only.
module i2c_mem_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         DEPTH      = 16,
  localparam int        PW         = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          scl,
  inout  wire           sda,
  output logic          busy,
  output logic          done,
  output logic          mem_wr,
  output logic [PW-1:0] mem_waddr,
  output logic [7:0]    mem_wdata
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, WAIT_STOP
  } state_t;

  state_t        state, state_d;
  logic          scl_m, scl_s, scl_h, sda_m, sda_s, sda_h;
  logic          scl_rise, scl_fall, start_det, stop_det;
  logic [2:0]    bitcnt;
  logic [6:0]    shreg;
  logic [7:0]    byte_in;
  logic [PW-1:0] ptr;
  logic          rw, sda_oe;
  logic [7:0]    mem [DEPTH];

  assign sda = sda_oe ? 1'b0 : 1'bz;

  // Sync flops reset to the idle-bus level so leaving reset never fakes an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      {scl_m, scl_s, scl_h} <= 3'b111;
      {sda_m, sda_s, sda_h} <= 3'b111;
    end else begin
      {scl_m, scl_s, scl_h} <= {scl, scl_m, scl_s};
      {sda_m, sda_s, sda_h} <= {sda, sda_m, sda_s};
    end
  end

  assign scl_rise  = scl_s & ~scl_h;
  assign scl_fall  = ~scl_s & scl_h;
  assign start_det = scl_s & scl_h & sda_h & ~sda_s;
  assign stop_det  = scl_s & scl_h & ~sda_h & sda_s;
  assign byte_in   = {shreg, sda_s};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // ACK states use sda_oe as the phase bit: first fall drives, second fall exits.
  always_comb begin
    state_d = state;
    if (stop_det)       state_d = IDLE;
    else if (start_det) state_d = ADDR;
    else begin
      case (state)
        ADDR:      if (scl_rise && bitcnt == 3'd7)
                     state_d = (byte_in[7:1] == SLAVE_ADDR) ? ADDR_ACK : WAIT_STOP;
        ADDR_ACK:  if (scl_fall && sda_oe) state_d = rw ? RDATA : PTR;
        PTR:       if (scl_rise && bitcnt == 3'd7) state_d = PTR_ACK;
        PTR_ACK:   if (scl_fall && sda_oe) state_d = WDATA;
        WDATA:     if (scl_rise && bitcnt == 3'd7) state_d = WDATA_ACK;
        WDATA_ACK: if (scl_fall && sda_oe) state_d = WDATA;
        RDATA:     if (scl_fall && bitcnt == 3'd7) state_d = RACK;
        RACK:      if (scl_rise && sda_s) state_d = WAIT_STOP;
                   else if (scl_fall)     state_d = RDATA;
        default:   state_d = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bitcnt    <= '0;
      shreg     <= '0;
      ptr       <= '0;
      rw        <= 1'b0;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_wr    <= 1'b0;
      mem_waddr <= '0;
      mem_wdata <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      done   <= 1'b0;
      mem_wr <= 1'b0;
      if (stop_det) begin
        sda_oe <= 1'b0;
        busy   <= 1'b0;
        done   <= busy;
      end else if (start_det) begin
        sda_oe <= 1'b0;
        bitcnt <= '0;
      end else begin
        case (state)
          ADDR, PTR, WDATA: if (scl_rise) begin
            shreg  <= byte_in[6:0];
            bitcnt <= bitcnt + 3'd1;
            if (bitcnt == 3'd7) begin
              if (state == ADDR) rw  <= byte_in[0];
              if (state == PTR)  ptr <= byte_in[PW-1:0];
              if (state == WDATA) begin
                mem[ptr]  <= byte_in;
                mem_wr    <= 1'b1;
                mem_waddr <= ptr;
                mem_wdata <= byte_in;
                ptr       <= ptr + PW'(1);
              end
            end
          end
          ADDR_ACK: if (scl_fall) begin
            bitcnt <= '0;
            if (!sda_oe) begin
              sda_oe <= 1'b1;
              busy   <= 1'b1;
            end else if (rw) begin
              shreg  <= mem[ptr][6:0];
              sda_oe <= ~mem[ptr][7];
            end else begin
              sda_oe <= 1'b0;
            end
          end
          PTR_ACK, WDATA_ACK: if (scl_fall) begin
            sda_oe <= ~sda_oe;
            bitcnt <= '0;
          end
          RDATA: if (scl_fall) begin
            if (bitcnt == 3'd7) begin
              sda_oe <= 1'b0;
              ptr    <= ptr + PW'(1);
              bitcnt <= '0;
            end else begin
              sda_oe <= ~shreg[6];
              shreg  <= {shreg[5:0], 1'b0};
              bitcnt <= bitcnt + 3'd1;
            end
          end
          // A NACK leaves on the rise, so a fall here always means "send next byte".
          RACK: if (scl_fall) begin
            shreg  <= mem[ptr][6:0];
            sda_oe <= ~mem[ptr][7];
            bitcnt <= '0;
          end
          default: sda_oe <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_mem_slave.sv
// Directed bench: a bit-banged I2C master drives frames at 32 clk per bit and
// checks ACKs, committed writes, read-back data and the reset/abort corners.
module tb_i2c_mem_slave;
  localparam int Q = 8;

  logic       clk = 1'b0, rst = 1'b1, scl = 1'b1, m_low = 1'b0;
  wire        sda;
  logic       busy, done, mem_wr;
  logic [3:0] mem_waddr;
  logic [7:0] mem_wdata;

  pullup (sda);
  assign sda = m_low ? 1'b0 : 1'bz;

  i2c_mem_slave #(.SLAVE_ADDR(7'h50), .DEPTH(16)) dut (
    .clk(clk), .rst(rst), .scl(scl), .sda(sda), .busy(busy), .done(done),
    .mem_wr(mem_wr), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
  );

  always #5 clk = ~clk;

  int         wr_cnt = 0, done_cnt = 0, drove_cnt = 0, busy_cnt = 0;
  logic [3:0] wa_log [64];
  logic [7:0] wd_log [64];

  always @(posedge clk) begin
    if (mem_wr) begin
      wa_log[wr_cnt[5:0]] <= mem_waddr;
      wd_log[wr_cnt[5:0]] <= mem_wdata;
      wr_cnt <= wr_cnt + 1;
    end
    if (done) done_cnt <= done_cnt + 1;
    if (!m_low && sda === 1'b0) drove_cnt <= drove_cnt + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
  end

  int checks = 0, errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_low = 1'b0; wait_q(); scl = 1'b1; wait_q(); m_low = 1'b1; wait_q(); scl = 1'b0; wait_q();
  endtask

  task automatic i2c_stop();
    m_low = 1'b1; wait_q(); scl = 1'b1; wait_q(); m_low = 1'b0; wait_q();
  endtask

  task automatic wbit(input logic b);
    m_low = ~b; wait_q(); scl = 1'b1; wait_q(); wait_q(); scl = 1'b0; wait_q();
  endtask

  task automatic rbit(output logic b);
    m_low = 1'b0; wait_q(); scl = 1'b1; wait_q(); b = sda; wait_q(); scl = 1'b0; wait_q();
  endtask

  task automatic wbyte(input logic [7:0] v, input logic exp_ack, input string name);
    logic a;
    for (int i = 7; i >= 0; i--) wbit(v[i]);
    rbit(a);
    chk(name, int'(a), int'(exp_ack));
  endtask

  task automatic rbyte(output logic [7:0] v, input logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      rbit(b);
      v[i] = b;
    end
    wbit(ack);
  endtask

  typedef struct {
    logic [7:0] ptr, d0, d1;
    logic [3:0] a0, a1;
  } vec_t;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t       vt [3];
    logic [7:0] r0, r1;
    int         wb, db, dvb, bb;

    vt[0] = '{ptr: 8'h03, d0: 8'hA5, d1: 8'h5A, a0: 4'h3, a1: 4'h4};
    vt[1] = '{ptr: 8'h0F, d0: 8'h11, d1: 8'h22, a0: 4'hF, a1: 4'h0};
    vt[2] = '{ptr: 8'hF8, d0: 8'h3C, d1: 8'hC3, a0: 4'h8, a1: 4'h9};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_mem_wr", int'(mem_wr), 0);
    chk("rst_waddr", int'(mem_waddr), 0);
    chk("rst_wdata", int'(mem_wdata), 0);
    chk("rst_sda", int'(sda), 1);
    wait_q();

    // Write two bytes, then random-read them back through a repeated START.
    for (int i = 0; i < 3; i++) begin
      wb = wr_cnt; db = done_cnt;
      i2c_start();
      wbyte(8'hA0, 1'b0, "w_addr_ack");
      wbyte(vt[i].ptr, 1'b0, "w_ptr_ack");
      wbyte(vt[i].d0, 1'b0, "w_d0_ack");
      wbyte(vt[i].d1, 1'b0, "w_d1_ack");
      i2c_stop();
      wait_q();
      chk("wr_count", wr_cnt - wb, 2);
      chk("wr_addr0", int'(wa_log[wb[5:0]]), int'(vt[i].a0));
      chk("wr_data0", int'(wd_log[wb[5:0]]), int'(vt[i].d0));
      chk("wr_addr1", int'(wa_log[wb[5:0] + 6'd1]), int'(vt[i].a1));
      chk("wr_data1", int'(wd_log[wb[5:0] + 6'd1]), int'(vt[i].d1));
      chk("wr_done", done_cnt - db, 1);

      i2c_start();
      wbyte(8'hA0, 1'b0, "r_addr_ack");
      wbyte(vt[i].ptr, 1'b0, "r_ptr_ack");
      i2c_start();
      wbyte(8'hA1, 1'b0, "r_addrR_ack");
      rbyte(r0, 1'b0);
      rbyte(r1, 1'b1);
      wait_q();
      chk("nack_release", int'(sda), 1);
      i2c_stop();
      wait_q();
      chk("rd_byte0", int'(r0), int'(vt[i].d0));
      chk("rd_byte1", int'(r1), int'(vt[i].d1));
    end

    // Wrong address: target must stay silent and idle.
    wb = wr_cnt; db = done_cnt; dvb = drove_cnt; bb = busy_cnt;
    i2c_start();
    wbyte(8'hA2, 1'b1, "bad_addr_nack");
    wbyte(8'h03, 1'b1, "bad_ptr_nack");
    wbyte(8'h55, 1'b1, "bad_data_nack");
    i2c_stop();
    wait_q();
    chk("bad_sda_driven", drove_cnt - dvb, 0);
    chk("bad_busy", busy_cnt - bb, 0);
    chk("bad_mem_wr", wr_cnt - wb, 0);
    chk("bad_done", done_cnt - db, 0);

    // STOP after 4 data bits: no write, ptr stays at 8.
    wb = wr_cnt; db = done_cnt;
    i2c_start();
    wbyte(8'hA0, 1'b0, "part_addr_ack");
    wbyte(8'h08, 1'b0, "part_ptr_ack");
    for (int i = 0; i < 4; i++) wbit(1'b1);
    i2c_stop();
    wait_q();
    chk("part_mem_wr", wr_cnt - wb, 0);
    chk("part_done", done_cnt - db, 1);
    chk("part_busy", int'(busy), 0);
    i2c_start();
    wbyte(8'hA1, 1'b0, "part_rd_ack");
    rbyte(r0, 1'b1);
    i2c_stop();
    wait_q();
    chk("part_ptr_kept", int'(r0), 8'h3C);

    // Reset while the target drives a 0 data bit (mem[7] = 00).
    i2c_start();
    wbyte(8'hA0, 1'b0, "rst_addr_ack");
    wbyte(8'h07, 1'b0, "rst_ptr_ack");
    i2c_start();
    wbyte(8'hA1, 1'b0, "rst_addrR_ack");
    m_low = 1'b0;
    wait_q();
    chk("rst_pre_drive", int'(sda), 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_sda_release", int'(sda), 1);
    chk("rst_busy_clear", int'(busy), 0);
    wait_q();
    i2c_start();
    wbyte(8'hA1, 1'b0, "post_rst_ack");
    rbyte(r0, 1'b1);
    i2c_stop();
    wait_q();
    chk("post_rst_mem0", int'(r0), 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
